serial_sub_slt: RTL and testbench

- Multi-cycle, bit-serial subtractor that computes A - B as A + ~B + 1, one slice per clock.
- Produces the difference, carryout and overflow, plus the signed less-than flag (overflow XOR difference sign bit).
- It is the producer side of the SLT path: it generates the sum and overflow values that the combinational SLT stage consumes.
- Intended for the low-area ALU variant; it sits between the register-file operand latches and the writeback mux.

---
 rtl/alu_pkg.sv | 13 +
 rtl/serial_sub_slt_if.sv | 27 ++
 rtl/serial_slice_adder.sv | 26 ++
 rtl/serial_sub_slt.sv | 113 +++++++++++
 tb/tb_serial_sub_slt.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding and default datapath width.
// Pure declarations, no logic.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/serial_sub_slt_if.sv
// Operand/result bundle between the operand latches and the serial subtractor.
// master drives start and operands; slave returns status and registered results.
interface serial_sub_slt_if
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] difference;
   logic             carryout;
   logic             overflow;
   logic             less;

   modport master (
      output start, operand_a, operand_b,
      input  busy, done, difference, carryout, overflow, less
   );

   modport slave (
      input  start, operand_a, operand_b,
      output busy, done, difference, carryout, overflow, less
   );
endinterface

// File: rtl/serial_slice_adder.sv
// SLICE-bit xor-based ripple adder; combinational, zero latency.
// Also exposes the carry into its top bit so the caller can form signed overflow.
module serial_slice_adder #(
   parameter int SLICE = 1
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] sum,
   output logic             cout,
   output logic             ctop
);
   logic [SLICE:0]   c;
   logic [SLICE-1:0] p;

   assign c[0] = cin;

   for (genvar i = 0; i < SLICE; i++) begin : g_bit
      assign p[i]   = a[i] ^ b[i];
      assign sum[i] = p[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
   end

   assign cout = c[SLICE];
   assign ctop = c[SLICE-1];
endmodule

// File: rtl/serial_sub_slt.sv
// Bit-serial A - B (A + ~B + 1) with carryout, overflow and signed less-than; WIDTH/SLICE cycles.
// No backpressure: start is only honoured in IDLE/DONE and ignored while busy.
module serial_sub_slt
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int SLICE = 1
) (
   input  logic           clk,
   input  logic           reset,
   serial_sub_slt_if.slave bus
);
   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if ((WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("serial_sub_slt: WIDTH must be a multiple of SLICE");
   end

   state_t           state, next_state;
   logic             accept;
   logic             last;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr, b_sr, d_sr;
   logic             carry;

   logic [WIDTH-1:0] diff_q;
   logic             carryout_q, overflow_q, less_q;

   logic [SLICE-1:0]       sum;
   logic                   cout, ctop;
   logic [WIDTH+SLICE-1:0] d_cat;
   logic [WIDTH-1:0]       d_next;

   serial_slice_adder #(.SLICE(SLICE)) u_add (
      .a    (a_sr[SLICE-1:0]),
      .b    (~b_sr[SLICE-1:0]),
      .cin  (carry),
      .sum  (sum),
      .cout (cout),
      .ctop (ctop)
   );

   // New slice enters at the MSB end so the word is LSB-aligned after N shifts.
   assign d_cat  = {sum, d_sr};
   assign d_next = d_cat[WIDTH+SLICE-1:SLICE];
   assign last   = (cnt == LAST);

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            if (last) next_state = DONE;
         end
         DONE: begin
            accept     = bus.start;
            next_state = bus.start ? RUN : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         a_sr       <= '0;
         b_sr       <= '0;
         d_sr       <= '0;
         carry      <= 1'b0;
         diff_q     <= '0;
         carryout_q <= 1'b0;
         overflow_q <= 1'b0;
         less_q     <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            a_sr  <= bus.operand_a;
            b_sr  <= bus.operand_b;
            d_sr  <= '0;
            carry <= 1'b1;
            cnt   <= '0;
         end else if (state == RUN) begin
            a_sr  <= a_sr >> SLICE;
            b_sr  <= b_sr >> SLICE;
            d_sr  <= d_next;
            carry <= cout;
            cnt   <= cnt + 1'b1;
            if (last) begin
               diff_q     <= d_next;
               carryout_q <= cout;
               overflow_q <= ctop ^ cout;
               less_q     <= (ctop ^ cout) ^ sum[SLICE-1];
            end
         end
      end
   end

   assign bus.busy       = (state == RUN);
   assign bus.done       = (state == DONE);
   assign bus.difference = diff_q;
   assign bus.carryout   = carryout_q;
   assign bus.overflow   = overflow_q;
   assign bus.less       = less_q;
endmodule

// File: tb/tb_serial_sub_slt.sv
// Directed bench for serial_sub_slt: SLICE=1 and SLICE=8 instances, 32-bit operands.
module tb_serial_sub_slt;
   logic clk = 1'b0;
   logic reset;
   int   nchecks = 0;
   int   nerr    = 0;

   serial_sub_slt_if #(.WIDTH(32)) bus1 ();
   serial_sub_slt_if #(.WIDTH(32)) bus8 ();

   serial_sub_slt #(.WIDTH(32), .SLICE(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   serial_sub_slt #(.WIDTH(32), .SLICE(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic [31:0] d, input logic co,
                          input logic ov, input logic ls);
      chk({tag, ".diff"}, 64'(bus1.difference), 64'(d));
      chk({tag, ".carryout"}, 64'(bus1.carryout), 64'(co));
      chk({tag, ".overflow"}, 64'(bus1.overflow), 64'(ov));
      chk({tag, ".less"}, 64'(bus1.less), 64'(ls));
   endtask

   // Returns at the negedge of the done cycle; lat counts edges after the accept edge.
   task automatic do_op1(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_bad);
      bus1.start     = 1'b1;
      bus1.operand_a = a;
      bus1.operand_b = b;
      @(negedge clk);
      bus1.start     = 1'b0;
      bus1.operand_a = $urandom;
      bus1.operand_b = $urandom;
      lat      = 0;
      busy_bad = 0;
      while (!bus1.done && lat < 100) begin
         if (bus1.busy !== 1'b1) busy_bad++;
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, bb, g, unstable, pulses, first;

      reset          = 1'b1;
      bus1.start     = 1'b0;
      bus1.operand_a = '0;
      bus1.operand_b = '0;
      bus8.start     = 1'b0;
      bus8.operand_a = '0;
      bus8.operand_b = '0;
      #3;
      chk("rst.busy", 64'(bus1.busy), 64'd0);
      chk("rst.done", 64'(bus1.done), 64'd0);
      chk_res("rst", 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 5 - 3
      do_op1(32'd5, 32'd3, lat, bb);
      chk("s1.latency", 64'(lat), 64'd32);
      chk("s1.busy_in_run", 64'(bb), 64'd0);
      chk("s1.busy_at_done", 64'(bus1.busy), 64'd0);
      chk_res("s1", 32'h2, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("s1.done_one_cycle", 64'(bus1.done), 64'd0);

      // 3 - 5
      do_op1(32'd3, 32'd5, lat, bb);
      chk("s2.latency", 64'(lat), 64'd32);
      chk_res("s2", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
      @(negedge clk);

      do_op1(32'h8000_0000, 32'h0000_0001, lat, bb);
      chk_res("s3", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
      @(negedge clk);

      do_op1(32'h7FFF_FFFF, 32'hFFFF_FFFF, lat, bb);
      chk_res("s4", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);

      // back-to-back: restart from the DONE cycle
      do_op1(32'd100, 32'd1, lat, bb);
      chk("b2b.latency1", 64'(lat), 64'd32);
      chk_res("b2b1", 32'd99, 1'b1, 1'b0, 1'b0);
      bus1.start     = 1'b1;
      bus1.operand_a = 32'd10;
      bus1.operand_b = 32'd10;
      @(negedge clk);
      bus1.start = 1'b0;
      chk("b2b.busy_rise", 64'(bus1.busy), 64'd1);
      chk("b2b.done_low", 64'(bus1.done), 64'd0);
      g        = 1;
      unstable = 0;
      while (!bus1.done && g < 100) begin
         if (bus1.difference !== 32'd99) unstable++;
         @(negedge clk);
         g++;
      end
      chk("b2b.gap_from_first_done", 64'(g), 64'd33);
      chk("b2b.first_result_stable", 64'(unstable), 64'd0);
      chk_res("b2b2", 32'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("b2b.done_one_cycle", 64'(bus1.done), 64'd0);

      // start during RUN is ignored
      bus1.start     = 1'b1;
      bus1.operand_a = 32'h1234;
      bus1.operand_b = 32'h0234;
      @(negedge clk);
      pulses = 0;
      first  = -1;
      for (int k = 0; k < 45; k++) begin
         if (k == 6) begin
            bus1.start     = 1'b1;
            bus1.operand_a = 32'hFFFF;
            bus1.operand_b = 32'h1;
         end else begin
            bus1.start = 1'b0;
         end
         if (bus1.done) begin
            pulses++;
            if (first < 0) first = k;
         end
         @(negedge clk);
      end
      chk("ign.first_done", 64'(first), 64'd32);
      chk("ign.pulses", 64'(pulses), 64'd1);
      chk_res("ign", 32'h1000, 1'b1, 1'b0, 1'b0);

      // asynchronous reset in the middle of RUN
      bus1.start     = 1'b1;
      bus1.operand_a = 32'h77;
      bus1.operand_b = 32'h11;
      @(negedge clk);
      bus1.start = 1'b0;
      repeat (14) @(negedge clk);
      chk("arst.busy_before", 64'(bus1.busy), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst.busy", 64'(bus1.busy), 64'd0);
      chk("arst.done", 64'(bus1.done), 64'd0);
      chk_res("arst", 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset  = 1'b0;
      pulses = 0;
      repeat (40) begin
         if (bus1.done) pulses++;
         @(negedge clk);
      end
      chk("arst.no_done", 64'(pulses), 64'd0);
      chk("arst.result_cleared", 64'(bus1.difference), 64'd0);
      do_op1(32'hFFFF_FFFF, 32'h1, lat, bb);
      chk("arst.relat", 64'(lat), 64'd32);
      chk_res("arst.re", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);
      @(negedge clk);

      // SLICE=8 instance
      bus8.start     = 1'b1;
      bus8.operand_a = 32'd5;
      bus8.operand_b = 32'd3;
      @(negedge clk);
      bus8.start = 1'b0;
      lat = 0;
      while (!bus8.done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("s8.latency", 64'(lat), 64'd4);
      chk("s8.diff", 64'(bus8.difference), 64'd2);
      chk("s8.carryout", 64'(bus8.carryout), 64'd1);
      chk("s8.overflow", 64'(bus8.overflow), 64'd0);
      chk("s8.less", 64'(bus8.less), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end
endmodule
